lamp_fpu_sqrt_iter: RTL and testbench



---
 rtl/lamp_fpu_sqrt_iter.sv | 224 ++++++++++++++++++++++
 tb/tb_lamp_fpu_sqrt_iter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/lamp_fpu_sqrt_iter.sv
// -----------------------------------------------------------------------------
// lamp_fpu_sqrt_iter
//   Parametrised iterative square-root unit. Takes an unpacked operand
//   (sign, biased exponent, mantissa with hidden bit, class flags) and
//   returns sign/exponent/fraction ready for the pack stage.
//
//   Normal operands run a restoring digit-by-digit square root, one root bit
//   per cycle for R = F_DW+2 cycles (hidden + fraction + guard). A final
//   ROUND cycle applies round-to-nearest-even using the guard bit and a
//   sticky bit taken from the final remainder. Special operands are resolved
//   on the accept edge.
//
// Ports
//   clk, rst         clock (rising edge), asynchronous active-low reset
//   doSqrt_i         request, accepted when doSqrt_i & ready_o
//   signum_op_i      operand sign
//   extExp_op_i      biased operand exponent
//   extMant_op_i     operand mantissa, hidden bit at MSB
//   isInf/isZero/isSNAN/isQNAN_op_i   operand class flags
//   ready_o          idle, can accept a request
//   valid_o          one-cycle result strobe
//   s/e/f_res_o      result sign, biased exponent, fraction (held until next)
//   isInexact_o      result was rounded (qualified by valid_o)
//   isInvalid_o      invalid operation (qualified by valid_o)
// -----------------------------------------------------------------------------
module lamp_fpu_sqrt_iter #(
    parameter int E_DW   = 8,
    parameter int F_DW   = 7,
    parameter int E_BIAS = 2**(E_DW-1)-1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            doSqrt_i,
    input  logic            signum_op_i,
    input  logic [E_DW-1:0] extExp_op_i,
    input  logic [F_DW:0]   extMant_op_i,
    input  logic            isInf_op_i,
    input  logic            isZero_op_i,
    input  logic            isSNAN_op_i,
    input  logic            isQNAN_op_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic            s_res_o,
    output logic [E_DW-1:0] e_res_o,
    output logic [F_DW-1:0] f_res_o,
    output logic            isInexact_o,
    output logic            isInvalid_o
);

    localparam int R     = F_DW + 2;          // root bits: hidden + fraction + guard
    localparam int RAD_W = 2 * R;             // radicand, two bits consumed per cycle
    localparam int REM_W = R + 3;             // partial remainder incl. shifted-in pair
    localparam int CNT_W = $clog2(R + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(R - 1);
    localparam logic [E_DW:0]    BIAS_W   = (E_DW+1)'(E_BIAS);
    localparam logic [E_DW-1:0]  EXP_ONES = '1;
    localparam logic [F_DW-1:0]  QNAN_F   = {1'b1, {(F_DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, ROUND} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [RAD_W-1:0]  rad_q;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [R-1:0]      root_q, root_d;
    logic [E_DW-1:0]   exp_q;

    logic              valid_q, s_res_q, inexact_q, invalid_q;
    logic [E_DW-1:0]   e_res_q;
    logic [F_DW-1:0]   f_res_q;

    // ---------------------------------------------------------------------
    // Operand decode (used only on the accept edge)
    // ---------------------------------------------------------------------
    logic signed [E_DW:0] e_unb, e_half;
    logic [E_DW-1:0]      exp_calc;
    logic [RAD_W-1:0]     rad_init;
    logic                 is_special, sp_s, sp_inv;
    logic [E_DW-1:0]      sp_e;
    logic [F_DW-1:0]      sp_f;

    always_comb begin
        e_unb    = $signed({1'b0, extExp_op_i} - BIAS_W);
        // Arithmetic halving keeps negative odd exponents correct: the odd
        // remainder is folded into the radicand below.
        e_half   = e_unb >>> 1;
        exp_calc = E_DW'(BIAS_W + e_half);

        // Radicand has two integer bits; an odd exponent doubles it so the
        // remaining exponent is even.
        if (e_unb[0])
            rad_init = {extMant_op_i, 1'b0, {(RAD_W-F_DW-2){1'b0}}};
        else
            rad_init = {1'b0, extMant_op_i, {(RAD_W-F_DW-2){1'b0}}};

        // Special-case priority: sNaN, qNaN, zero/subnormal, negative, +inf.
        is_special = 1'b1;
        sp_s       = 1'b0;
        sp_e       = EXP_ONES;
        sp_f       = QNAN_F;
        sp_inv     = 1'b0;
        if (isSNAN_op_i) begin
            sp_inv = 1'b1;
        end else if (isQNAN_op_i) begin
            sp_inv = 1'b0;
        end else if (isZero_op_i || (extExp_op_i == '0)) begin
            sp_s = signum_op_i;
            sp_e = '0;
            sp_f = '0;
        end else if (signum_op_i) begin
            sp_inv = 1'b1;
        end else if (isInf_op_i) begin
            sp_f = '0;
        end else begin
            is_special = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // One restoring step: bring down the next radicand pair and try to
    // subtract (4*root + 1).
    // ---------------------------------------------------------------------
    logic [REM_W-1:0] rem_sh, trial;

    always_comb begin
        rem_sh = {rem_q[REM_W-3:0], rad_q[RAD_W-1 -: 2]};
        trial  = {1'b0, root_q, 2'b01};
        if (rem_sh >= trial) begin
            rem_d  = rem_sh - trial;
            root_d = {root_q[R-2:0], 1'b1};
        end else begin
            rem_d  = rem_sh;
            root_d = {root_q[R-2:0], 1'b0};
        end
    end

    // ---------------------------------------------------------------------
    // Round to nearest even
    // ---------------------------------------------------------------------
    logic            guard, sticky, rnd_inc, frac_cy, exp_inc;
    logic [F_DW-1:0] frac_rnd;

    always_comb begin
        guard              = root_q[0];
        sticky             = |rem_q;
        rnd_inc            = guard & (sticky | root_q[1]);
        {frac_cy, frac_rnd} = {1'b0, root_q[R-2:1]} + {{F_DW{1'b0}}, rnd_inc};
        // Fraction wrap past 1.11..1 means the mantissa reached 2.0.
        exp_inc            = frac_cy & root_q[R-1];
    end

    // ---------------------------------------------------------------------
    // FSM with registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rad_q     <= '0;
            rem_q     <= '0;
            root_q    <= '0;
            exp_q     <= '0;
            valid_q   <= 1'b0;
            s_res_q   <= 1'b0;
            e_res_q   <= '0;
            f_res_q   <= '0;
            inexact_q <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (doSqrt_i) begin
                        if (is_special) begin
                            valid_q   <= 1'b1;
                            s_res_q   <= sp_s;
                            e_res_q   <= sp_e;
                            f_res_q   <= sp_f;
                            inexact_q <= 1'b0;
                            invalid_q <= sp_inv;
                        end else begin
                            state_q <= ITER;
                            cnt_q   <= '0;
                            rad_q   <= rad_init;
                            rem_q   <= '0;
                            root_q  <= '0;
                            exp_q   <= exp_calc;
                        end
                    end
                end
                ITER: begin
                    rad_q  <= rad_q << 2;
                    rem_q  <= rem_d;
                    root_q <= root_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ROUND;
                        cnt_q   <= '0;
                    end
                end
                ROUND: begin
                    state_q   <= IDLE;
                    valid_q   <= 1'b1;
                    s_res_q   <= 1'b0;
                    e_res_q   <= exp_q + {{(E_DW-1){1'b0}}, exp_inc};
                    f_res_q   <= frac_rnd;
                    inexact_q <= guard | sticky;
                    invalid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o     = (state_q == IDLE);
    assign valid_o     = valid_q;
    assign s_res_o     = s_res_q;
    assign e_res_o     = e_res_q;
    assign f_res_o     = f_res_q;
    assign isInexact_o = inexact_q;
    assign isInvalid_o = invalid_q;

endmodule

// File: tb/tb_lamp_fpu_sqrt_iter.sv
// Scoreboard bench for lamp_fpu_sqrt_iter (default E_DW=8, F_DW=7).
// The driver pushes hand-computed expectations when a request is accepted;
// the monitor pops and compares whenever valid_o is seen.
module tb_lamp_fpu_sqrt_iter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       doSqrt = 1'b0;
    logic       signum = 1'b0;
    logic [7:0] extExp = '0;
    logic [7:0] extMant = '0;
    logic       isInf = 1'b0, isZero = 1'b0, isSNAN = 1'b0, isQNAN = 1'b0;
    logic       ready_o, valid_o, s_res_o, isInexact_o, isInvalid_o;
    logic [7:0] e_res_o;
    logic [6:0] f_res_o;

    lamp_fpu_sqrt_iter dut (
        .clk         (clk),
        .rst         (rst),
        .doSqrt_i    (doSqrt),
        .signum_op_i (signum),
        .extExp_op_i (extExp),
        .extMant_op_i(extMant),
        .isInf_op_i  (isInf),
        .isZero_op_i (isZero),
        .isSNAN_op_i (isSNAN),
        .isQNAN_op_i (isQNAN),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .s_res_o     (s_res_o),
        .e_res_o     (e_res_o),
        .f_res_o     (f_res_o),
        .isInexact_o (isInexact_o),
        .isInvalid_o (isInvalid_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        logic       s;
        logic [7:0] e;
        logic [6:0] f;
        logic       inex;
        logic       inv;
        int         lat;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst && valid_o) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check({x.name, ".s"},    {31'd0, s_res_o},     {31'd0, x.s});
                check({x.name, ".e"},    {24'd0, e_res_o},     {24'd0, x.e});
                check({x.name, ".f"},    {25'd0, f_res_o},     {25'd0, x.f});
                check({x.name, ".inex"}, {31'd0, isInexact_o}, {31'd0, x.inex});
                check({x.name, ".inv"},  {31'd0, isInvalid_o}, {31'd0, x.inv});
                check({x.name, ".lat"},  32'(cyc - x.acc),     32'(x.lat));
            end
        end
    end

    // Drive a request (holding doSqrt high while busy) and push expectation.
    task automatic issue(input string nm, input logic sg, input logic [7:0] ex,
                         input logic [7:0] mn, input logic [3:0] cls,
                         input logic es, input logic [7:0] ee, input logic [6:0] ef,
                         input logic einx, input logic einv, input int elat);
        exp_t x;
        int   n;
        @(negedge clk);
        signum  = sg;
        extExp  = ex;
        extMant = mn;
        {isInf, isZero, isSNAN, isQNAN} = cls;
        doSqrt  = 1'b1;
        n = 0;
        while (!ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            check({nm, ".ready_timeout"}, 32'd0, 32'd1);
            doSqrt = 1'b0;
        end else begin
            x.name = nm; x.s = es; x.e = ee; x.f = ef;
            x.inex = einx; x.inv = einv; x.lat = elat; x.acc = cyc;
            @(posedge clk);
            sb.push_back(x);
            #1 doSqrt = 1'b0;
        end
    endtask

    // class flags: {inf, zero, snan, qnan}
    initial begin
        #3 rst = 1'b0;
        #1;
        check("rst.valid", {31'd0, valid_o}, 32'd0);
        check("rst.ready", {31'd0, ready_o}, 32'd1);
        check("rst.e",     {24'd0, e_res_o}, 32'd0);
        check("rst.f",     {25'd0, f_res_o}, 32'd0);
        check("rst.flags", {29'd0, s_res_o, isInexact_o, isInvalid_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Normal path
        issue("sqrt4",   0, 8'd129, 8'h80, 4'b0000, 0, 8'd128, 7'h00, 0, 0, 11);
        issue("sqrt2",   0, 8'd128, 8'h80, 4'b0000, 0, 8'd127, 7'h35, 1, 0, 11);
        issue("sqrt3",   0, 8'd128, 8'hC0, 4'b0000, 0, 8'd127, 7'h5E, 1, 0, 11);
        issue("sqrt9",   0, 8'd130, 8'h90, 4'b0000, 0, 8'd128, 7'h40, 0, 0, 11);
        issue("sqrt1",   0, 8'd127, 8'h80, 4'b0000, 0, 8'd127, 7'h00, 0, 0, 11);
        issue("sqrt0p5", 0, 8'd126, 8'h80, 4'b0000, 0, 8'd126, 7'h35, 1, 0, 11);
        // Specials
        issue("neg1",    1, 8'd127, 8'h80, 4'b0000, 0, 8'hFF, 7'h40, 0, 1, 1);
        issue("snan",    0, 8'hFF,  8'hA0, 4'b0010, 0, 8'hFF, 7'h40, 0, 1, 1);
        issue("qnan",    1, 8'hFF,  8'hC0, 4'b0001, 0, 8'hFF, 7'h40, 0, 0, 1);
        issue("negzero", 1, 8'h00,  8'h00, 4'b0100, 1, 8'h00, 7'h00, 0, 0, 1);
        issue("posinf",  0, 8'hFF,  8'h80, 4'b1000, 0, 8'hFF, 7'h00, 0, 0, 1);
        issue("neginf",  1, 8'hFF,  8'h80, 4'b1000, 0, 8'hFF, 7'h40, 0, 1, 1);
        issue("subnorm", 1, 8'h00,  8'h40, 4'b0000, 1, 8'h00, 7'h00, 0, 0, 1);
        // Back-to-back: second request held high while busy, taken on valid cycle
        issue("b2b_4",   0, 8'd129, 8'h80, 4'b0000, 0, 8'd128, 7'h00, 0, 0, 11);
        issue("b2b_025", 0, 8'd125, 8'h80, 4'b0000, 0, 8'd126, 7'h00, 0, 0, 11);

        // Wait for scoreboard to drain
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("drain", 32'(sb.size()), 32'd0);

        // Reset mid-ITER aborts: no valid_o afterwards
        @(negedge clk);
        signum = 0; extExp = 8'd129; extMant = 8'h80;
        {isInf, isZero, isSNAN, isQNAN} = 4'b0000;
        doSqrt = 1'b1;
        @(posedge clk);
        #1 doSqrt = 1'b0;
        check("abort.busy", {31'd0, ready_o}, 32'd0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort.valid", {31'd0, valid_o}, 32'd0);
        check("abort.ready", {31'd0, ready_o}, 32'd1);
        check("abort.e",     {24'd0, e_res_o}, 32'd0);
        check("abort.f",     {25'd0, f_res_o}, 32'd0);
        doSqrt = 1'b1;                    // ignored while in reset
        repeat (2) @(negedge clk);
        rst = 1'b1;
        doSqrt = 1'b0;
        #1;
        check("release.ready", {31'd0, ready_o}, 32'd1);
        repeat (15) @(negedge clk);       // monitor flags any stray valid_o

        // A request after reset still works
        issue("post_rst", 0, 8'd130, 8'h90, 4'b0000, 0, 8'd128, 7'h40, 0, 0, 11);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("drain2", 32'(sb.size()), 32'd0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
